line_burst_adapter: RTL and testbench
=====================================

// Module: line_burst_adapter
// PURPOSE
//  Memory-side responder for the L1 cache's 256-bit line interface (pmem_read/pmem_write/pmem_resp).
//  Accepts one line request at a time and performs it as a 4-beat x 64-bit burst on physical memory.
//  On a read it gathers the four beats into one line; on a write it splits the line into four beats.
//  It returns a single-cycle completion to the cache. It sits between the cache and main memory/arbiter.
// PARAMETERS
//  ADDR_W  32   address width
//  LINE_W  256  cache line width (bits)
//  BEAT_W  64   memory beat width (bits)
//  BEATS   4    LINE_W/BEAT_W; must be a power of 2; beat counter is $clog2(BEATS) bits
//  OFFSET  5    log2(LINE_W/8); low address bits forced to 0 toward memory
// PORTS
//  clk          in   1       clock; all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  line_read_i  in   1       cache requests line read (held until line_resp_o)
//  line_write_i in   1       cache requests line write (held until line_resp_o)
//  line_addr_i  in   ADDR_W  line address from cache
//  line_wdata_i in   LINE_W  line to write; valid while line_write_i is high
//  line_rdata_o out  LINE_W  assembled read line
//  line_resp_o  out  1       one-cycle completion pulse
//  mem_read_o   out  1       burst read request to memory
//  mem_write_o  out  1       burst write request to memory
//  mem_addr_o   out  ADDR_W  {latched addr[ADDR_W-1:OFFSET], OFFSET'b0}
//  mem_wdata_o  out  BEAT_W  current write beat
//  mem_rdata_i  in   BEAT_W  read beat, valid when mem_resp_i=1
//  mem_resp_i   in   1       per-beat handshake; one beat transferred per high cycle
// BEHAVIOUR
//  Reset (async): state=IDLE, beat count=0, all outputs 0, line buffer cleared to 0.
//  FSM: IDLE -> RD | WR -> DONE -> IDLE.
//   IDLE: if line_write_i=1, latch addr and line_wdata_i, go to WR. Write wins if both requests are high.
//         Else if line_read_i=1, latch addr and go to RD. Beat count is cleared on either transition.
//   RD:   mem_read_o=1. On each cycle with mem_resp_i=1, store mem_rdata_i into line slice [cnt*BEAT_W +: BEAT_W]
//         and increment cnt. Beat 0 is the least-significant slice. After beat BEATS-1 is stored, go to DONE.
//   WR:   mem_write_o=1 and mem_wdata_o = latched slice [cnt]. On each mem_resp_i=1, increment cnt.
//         After the resp for beat BEATS-1, go to DONE.
//   DONE: line_resp_o=1 for exactly one cycle; mem_read_o and mem_write_o are 0. Next state is always IDLE.
//  Request outputs are registered from state: first request cycle is the cycle after acceptance.
//  Minimum latency with zero wait states: request seen at edge N, beats at N+1..N+4, line_resp_o at N+5.
//  mem_resp_i gaps are legal. Beats advance only on resp, and mem_addr_o / mem_*_o are held stable across gaps.
//  mem_resp_i outside RD/WR is ignored. No beat is captured and no state changes.
//  line_rdata_o holds the last completed read line until the next read completes.
//   It is valid during line_resp_o and stays unchanged through a write.
//  The request is sampled only in IDLE. line_addr_i/line_wdata_i changes after acceptance have no effect.
//  The IDLE cycle after DONE may accept a new request. The cache must drop its request on seeing line_resp_o.
//  Beat counter wraps to 0 on the last beat (BEATS-1 -> 0); no overflow state exists.
//  Reset mid-burst aborts immediately: request outputs drop and no line_resp_o is issued.
// STRUCTURE
//  Package line_burst_pkg: state enum {IDLE,RD,WR,DONE}; LINE_W/BEAT_W/BEATS/OFFSET localparams.
//  One module, no sub-module. Contents: FSM register, beat counter, LINE_W line buffer (shared by read
//  assembly and write staging), address register, and combinational output decode from state.
// TESTING
//  1 Read, zero wait: read_i, addr=0x0000_1234; beats 0x11..,0x22..,0x33..,0x44.. on consecutive resp
//    -> mem_addr_o=0x0000_1220; line_rdata_o={0x44..,0x33..,0x22..,0x11..}; resp_o one cycle at N+5.
//  2 Write: line_wdata_i={D3,D2,D1,D0}, addr=0x8000_00FF, resp with 2-cycle gap after beat 1
//    -> mem_wdata_o D0,D1,(held D2 over gap),D2,D3; mem_addr_o=0x8000_00E0; single resp_o.
//  3 Both read_i and write_i high in IDLE -> write burst performed, mem_read_o never asserts.
//  4 Stray mem_resp_i=1 in IDLE for 3 cycles -> no state change, line_rdata_o unchanged, no resp_o.
//  5 rst asserted after beat 2 of a read -> same cycle: mem_read_o=0, state IDLE, line_rdata_o=0;
//    next read completes normally.
//  6 Back-to-back: write then read issued in the IDLE cycle right after DONE
//    -> read accepted; two resp_o pulses, 1 idle cycle apart minimum.

Source files
------------

// File: rtl/line_burst_pkg.sv
// Shared widths and FSM encoding for line_burst_adapter.
// Widths: 32-bit address, 256-bit line, 64-bit beats (4 beats per line), 32-byte line offset.
// Imported by line_burst_adapter.
package line_burst_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int OFFSET = $clog2(LINE_W / 8);
  localparam int CNT_W  = $clog2(BEATS);

  // Clears the byte-within-line bits so memory always sees a line-aligned address.
  localparam logic [ADDR_W-1:0] LINE_ADDR_MASK = ~ADDR_W'((1 << OFFSET) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/line_burst_adapter.sv
// Purpose: turns one 256-bit cache line read/write into a 4 x 64-bit memory burst.
// Latency: accept at edge N, beats N+1..N+4 with no wait states, line_resp_o sampled at N+5.
// Backpressure: memory stalls the burst by holding mem_resp_i low; request/address/data are held meanwhile.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   line_read_i/line_write_i    cache line request, held until line_resp_o (write wins if both)
//   line_addr_i, line_wdata_i   line address and write line, sampled only at acceptance
//   line_rdata_o, line_resp_o   last completed read line, one-cycle completion pulse
//   mem_read_o/mem_write_o      burst request toward memory, decoded from state
//   mem_addr_o, mem_wdata_o     line-aligned address, current write beat
//   mem_rdata_i, mem_resp_i     read beat and per-beat handshake
module line_burst_adapter
  import line_burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [ADDR_W-1:0] line_addr_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // One buffer serves both directions: read beats are assembled here and
  // write lines are staged here for slicing out beat by beat.
  logic [LINE_W-1:0] line_q, line_d;
  // Separate copy of the last finished read so a write burst (which reuses
  // the buffer) cannot disturb what the cache sees on line_rdata_o.
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              last_beat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    line_d    = line_q;
    rdata_d   = rdata_q;
    last_beat = (cnt_q == CNT_W'(BEATS - 1));

    case (state_q)
      IDLE: begin
        if (line_write_i) begin
          addr_d  = line_addr_i;
          line_d  = line_wdata_i;
          cnt_d   = '0;
          state_d = WR;
        end else if (line_read_i) begin
          addr_d  = line_addr_i;
          cnt_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (mem_resp_i) begin
          line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = mem_rdata_i;
          // Counter wraps to 0 on the final beat; no separate terminal value.
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            // Publish the completed line on the same edge that enters DONE so
            // it is already valid while line_resp_o is high.
            rdata_d = line_d;
            state_d = DONE;
          end
        end
      end
      WR: begin
        if (mem_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode directly from registered state, so a reset drops them at once.
  assign mem_read_o   = (state_q == RD);
  assign mem_write_o  = (state_q == WR);
  assign line_resp_o  = (state_q == DONE);
  assign mem_addr_o   = addr_q & LINE_ADDR_MASK;
  assign mem_wdata_o  = line_q[int'(cnt_q)*BEAT_W +: BEAT_W];
  assign line_rdata_o = rdata_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: directed scenarios plus randomized
// read/write bursts with random wait states, checked against a line-level model.
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read_i, line_write_i;
  logic [31:0]  line_addr_i;
  logic [255:0] line_wdata_i, line_rdata_o;
  logic         line_resp_o, mem_read_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [63:0]  mem_wdata_o, mem_rdata_i;
  logic         mem_resp_i;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the line the cache should currently see on line_rdata_o.
  logic [255:0] model_rdata;

  line_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_addr_i(line_addr_i), .line_wdata_i(line_wdata_i),
    .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Presents one line request and plays the memory side for four beats.
  // gaps[i] = idle cycles inserted before beat i. rline supplies read beats.
  // If chain is set the caller issues its next request in the DONE cycle.
  task automatic do_burst(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rline,
                          input logic [3:0][3:0] gaps, input bit chain,
                          output int acc_wait);
    bit          is_wr;
    int          beat, gap, cycles, exp_lat;
    logic [31:0] exp_addr;
    is_wr    = wr;
    exp_addr = addr & 32'hFFFF_FFE0;
    exp_lat  = 5 + int'(gaps[0]) + int'(gaps[1]) + int'(gaps[2]) + int'(gaps[3]);
    line_read_i = rd; line_write_i = wr; line_addr_i = addr; line_wdata_i = wline;
    acc_wait = 0;
    do begin
      @(posedge clk); #1; acc_wait++;
      tests_run++;
      if (!(mem_read_o || mem_write_o) && line_resp_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL accept_wait_resp: line_resp_o=%b while waiting, expected 0", line_resp_o);
      end
    end while (!(mem_read_o || mem_write_o) && acc_wait < 10);
    tests_run++;
    if (!(mem_read_o || mem_write_o)) begin
      tests_failed++;
      $display("FAIL accept_timeout: no burst started after %0d cycles", acc_wait);
      line_read_i = 0; line_write_i = 0;
      return;
    end
    // Inputs after acceptance must be ignored.
    line_addr_i = $urandom; line_wdata_i = rand_line();
    beat = 0; gap = int'(gaps[0]); cycles = 0;
    while (beat < 4 && cycles < 100) begin
      tests_run++;
      if ({mem_read_o, mem_write_o, line_resp_o, mem_addr_o} !== {~is_wr, is_wr, 1'b0, exp_addr}) begin
        tests_failed++;
        $display("FAIL burst_ctrl: rd=%b wr=%b resp=%b addr=%h, expected rd=%b wr=%b resp=0 addr=%h",
                 mem_read_o, mem_write_o, line_resp_o, mem_addr_o, ~is_wr, is_wr, exp_addr);
      end
      if (is_wr) begin
        tests_run++;
        if (mem_wdata_o !== wline[beat*64 +: 64]) begin
          tests_failed++;
          $display("FAIL wr_beat%0d: mem_wdata_o=%h expected %h", beat, mem_wdata_o, wline[beat*64 +: 64]);
        end
        tests_run++;
        if (line_rdata_o !== model_rdata) begin
          tests_failed++;
          $display("FAIL rdata_hold_wr: line_rdata_o=%h expected %h", line_rdata_o, model_rdata);
        end
      end
      if (gap > 0) begin
        mem_resp_i = 1'b0; mem_rdata_i = {$urandom, $urandom}; gap--;
      end else begin
        mem_resp_i = 1'b1; mem_rdata_i = rline[beat*64 +: 64]; beat++;
        if (beat < 4) gap = int'(gaps[beat]);
      end
      @(posedge clk); #1; cycles++;
    end
    mem_resp_i = 1'b0; mem_rdata_i = '0; line_read_i = 0; line_write_i = 0;
    if (!is_wr) model_rdata = rline;
    tests_run++;
    if ({line_resp_o, mem_read_o, mem_write_o} !== 3'b100) begin
      tests_failed++;
      $display("FAIL done_ctrl: resp=%b rd=%b wr=%b expected resp=1 rd=0 wr=0", line_resp_o, mem_read_o, mem_write_o);
    end
    tests_run++;
    if (cycles + 1 !== exp_lat) begin
      tests_failed++;
      $display("FAIL latency: resp after %0d edges, expected %0d", cycles + 1, exp_lat);
    end
    tests_run++;
    if (line_rdata_o !== model_rdata) begin
      tests_failed++;
      $display("FAIL done_rdata: line_rdata_o=%h expected %h", line_rdata_o, model_rdata);
    end
    if (!chain) begin
      @(posedge clk); #1;
      tests_run++;
      if ({line_resp_o, mem_read_o, mem_write_o} !== 3'b000) begin
        tests_failed++;
        $display("FAIL resp_pulse: resp=%b rd=%b wr=%b after DONE, expected all 0", line_resp_o, mem_read_o, mem_write_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line_read_i = 0; line_write_i = 0; line_addr_i = '0; line_wdata_i = '0;
    mem_rdata_i = '0; mem_resp_i = 0;
    model_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({line_resp_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, line_rdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, expected all 0",
               line_resp_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, line_rdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    logic [255:0] rl;
    int aw;
    rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_burst(1'b1, 1'b0, 32'h0000_1234, '0, rl, '0, 1'b0, aw);
    tests_run++;
    if (line_rdata_o !== rl) begin
      tests_failed++;
      $display("FAIL read_line: line_rdata_o=%h expected %h", line_rdata_o, rl);
    end
  endtask

  task automatic test_write_gap();
    logic [3:0][3:0] g;
    int aw;
    g = '0; g[2] = 4'd2;
    do_burst(1'b0, 1'b1, 32'h8000_00FF, rand_line(), '0, g, 1'b0, aw);
  endtask

  task automatic test_both_requests();
    int aw;
    do_burst(1'b1, 1'b1, $urandom, rand_line(), '0, 16'h0101, 1'b0, aw);
  endtask

  task automatic test_stray_resp();
    for (int i = 0; i < 3; i++) begin
      mem_resp_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
      @(posedge clk); #1;
      tests_run++;
      if ({line_resp_o, mem_read_o, mem_write_o} !== 3'b000 || line_rdata_o !== model_rdata) begin
        tests_failed++;
        $display("FAIL stray_resp: resp=%b rd=%b wr=%b rdata=%h expected 0/0/0 rdata=%h",
                 line_resp_o, mem_read_o, mem_write_o, line_rdata_o, model_rdata);
      end
    end
    mem_resp_i = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int aw;
    line_read_i = 1'b1; line_addr_i = $urandom;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mem_resp_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    mem_resp_i = 1'b0;
    tests_run++;
    if (mem_read_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midread_active: mem_read_o=%b expected 1", mem_read_o);
    end
    rst = 1'b1; #1;
    model_rdata = '0;
    tests_run++;
    if ({line_resp_o, mem_read_o, mem_write_o, mem_addr_o, line_rdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL midread_reset: resp=%b rd=%b wr=%b addr=%h rdata=%h expected all 0",
               line_resp_o, mem_read_o, mem_write_o, mem_addr_o, line_rdata_o);
    end
    line_read_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      tests_run++;
      if ({line_resp_o, mem_read_o} !== 2'b00) begin
        tests_failed++;
        $display("FAIL post_reset_idle: resp=%b rd=%b expected 0/0", line_resp_o, mem_read_o);
      end
    end
    do_burst(1'b1, 1'b0, $urandom, '0, rand_line(), '0, 1'b0, aw);
  endtask

  task automatic test_back_to_back();
    int aw;
    do_burst(1'b0, 1'b1, $urandom, rand_line(), '0, '0, 1'b1, aw);
    // Read is raised in the DONE cycle; it must be taken in the following IDLE cycle.
    do_burst(1'b1, 1'b0, $urandom, '0, rand_line(), '0, 1'b0, aw);
    tests_run++;
    if (aw !== 2) begin
      tests_failed++;
      $display("FAIL b2b_accept: read started after %0d edges, expected 2", aw);
    end
  endtask

  task automatic test_random();
    logic [3:0][3:0] g;
    int aw;
    bit rd, wr;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) g[i] = 4'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_burst(rd, wr, $urandom, rand_line(), rand_line(), g, 1'($urandom_range(0, 1)), aw);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_gap();
    test_both_requests();
    test_stray_resp();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
